// File: rtl/synchronizer_lock_ctrl.sv
// Sequencing controller for the synchronizer frequency regulator: holds it in reset,
// loads its period target, then tracks lock / loss-of-lock / fault from its measurements.
module synchronizer_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned TOL          = 2,
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned ACQ_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] target_period,
  input  logic       psi,
  input  logic [8:0] duration,
  input  logic [7:0] adjusted_div,
  output logic       reg_rst,
  output logic [7:0] set_period,
  output logic       locked,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_REG = 3'd1,
    S_ACQUIRE   = 3'd2,
    S_LOCKED    = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [9:0] TOL_W     = 10'(TOL);
  localparam logic [8:0] LOCK_W    = 9'(LOCK_COUNT);
  localparam logic [8:0] UNLOCK_W  = 9'(UNLOCK_COUNT);
  localparam logic [8:0] TIMEOUT_W = 9'(ACQ_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] set_period_q, set_period_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic [7:0] bad_cnt_q, bad_cnt_d;
  logic [7:0] meas_cnt_q, meas_cnt_d;
  logic [7:0] relock_q, relock_d;
  logic       psi_q;

  logic       meas, in_win, rail;
  logic [9:0] dur_w, sp_w, err;
  logic [8:0] good_next, bad_next, meas_next;

  // Error is formed 10 bits wide so duration=511 against a small target never wraps.
  assign meas      = psi_q & ~psi;
  assign dur_w     = {1'b0, duration};
  assign sp_w      = {2'b00, set_period_q};
  assign err       = (dur_w >= sp_w) ? (dur_w - sp_w) : (sp_w - dur_w);
  assign in_win    = (err <= TOL_W);
  assign rail      = (adjusted_div == 8'h00) || (adjusted_div == 8'hFF);
  assign good_next = {1'b0, good_cnt_q} + 9'd1;
  assign bad_next  = {1'b0, bad_cnt_q} + 9'd1;
  assign meas_next = {1'b0, meas_cnt_q} + 9'd1;

  always_comb begin
    state_d      = state_q;
    set_period_d = set_period_q;
    rst_cnt_d    = rst_cnt_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    meas_cnt_d   = meas_cnt_q;
    relock_d     = relock_q;
    if (state_q == S_IDLE) begin
      set_period_d = target_period;
      rst_cnt_d    = 8'd0;
      good_cnt_d   = 8'd0;
      bad_cnt_d    = 8'd0;
      meas_cnt_d   = 8'd0;
      relock_d     = 8'd0;
      if (enable) state_d = S_RESET_REG;
    end else if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_RESET_REG: begin
          rst_cnt_d = rst_cnt_q + 8'd1;
          if (rst_cnt_q == RST_LAST) state_d = S_ACQUIRE;
        end
        S_ACQUIRE: if (meas) begin
          meas_cnt_d = meas_next[7:0];
          good_cnt_d = in_win ? good_next[7:0] : 8'd0;
          if (rail)                            state_d = S_FAULT;
          else if (in_win && good_next == LOCK_W) state_d = S_LOCKED;
          else if (meas_next == TIMEOUT_W)     state_d = S_FAULT;
        end
        S_LOCKED: if (meas) begin
          bad_cnt_d = in_win ? 8'd0 : bad_next[7:0];
          if (rail) begin
            state_d = S_FAULT;
          end else if (!in_win && bad_next == UNLOCK_W) begin
            state_d    = S_ACQUIRE;
            relock_d   = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
            good_cnt_d = 8'd0;
            bad_cnt_d  = 8'd0;
            meas_cnt_d = 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      set_period_q <= 8'd0;
      rst_cnt_q    <= 8'd0;
      good_cnt_q   <= 8'd0;
      bad_cnt_q    <= 8'd0;
      meas_cnt_q   <= 8'd0;
      relock_q     <= 8'd0;
      psi_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      set_period_q <= set_period_d;
      rst_cnt_q    <= rst_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      meas_cnt_q   <= meas_cnt_d;
      relock_q     <= relock_d;
      psi_q        <= psi;
    end
  end

  assign state      = state_q;
  assign set_period = set_period_q;
  assign relock_cnt = relock_q;
  assign locked     = (state_q == S_LOCKED);
  assign fault      = (state_q == S_FAULT);
  assign reg_rst    = (state_q == S_IDLE) || (state_q == S_RESET_REG) || (state_q == S_FAULT);

endmodule

// File: tb/tb_synchronizer_lock_ctrl.sv
// Bench for synchronizer_lock_ctrl: directed scenarios plus random traffic, all compared
// against a measurement-history reference model.
module tb_synchronizer_lock_ctrl;
  localparam int RST_CYCLES   = 4;
  localparam int TOL          = 2;
  localparam int LOCK_COUNT   = 8;
  localparam int UNLOCK_COUNT = 3;
  localparam int ACQ_TIMEOUT  = 64;
  localparam logic [21:0] RESET_VEC = {3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] target_period = 8'd0;
  logic       psi = 1'b0;
  logic [8:0] duration = 9'd0;
  logic [7:0] adjusted_div = 8'h80;
  logic       reg_rst, locked, fault;
  logic [7:0] set_period, relock_cnt;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  synchronizer_lock_ctrl #(
    .RST_CYCLES(RST_CYCLES), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT), .ACQ_TIMEOUT(ACQ_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .target_period(target_period),
    .psi(psi), .duration(duration), .adjusted_div(adjusted_div),
    .reg_rst(reg_rst), .set_period(set_period), .locked(locked), .fault(fault),
    .state(state), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus histories of in-window results per phase.
  int m_state, m_sp, m_relock, m_rcyc;
  bit m_psid;
  bit acq_hist[$];
  bit lck_hist[$];

  function automatic void model_reset();
    m_state = 0; m_sp = 0; m_relock = 0; m_rcyc = 0; m_psid = 0;
    acq_hist.delete();
    lck_hist.delete();
  endfunction

  function automatic void model_step();
    bit meas, inwin, rail, all;
    int err;
    if (!rst_n) begin
      model_reset();
      return;
    end
    meas  = m_psid && !psi;
    err   = int'(duration) - m_sp;
    if (err < 0) err = -err;
    inwin = (err <= TOL);
    rail  = (adjusted_div == 8'h00) || (adjusted_div == 8'hFF);
    m_psid = psi;
    if (m_state == 0) begin
      m_sp = int'(target_period);
      m_relock = 0; m_rcyc = 0;
      acq_hist.delete();
      lck_hist.delete();
      if (enable) m_state = 1;
    end else if (!enable) begin
      m_state = 0;
    end else if (m_state == 1) begin
      m_rcyc++;
      if (m_rcyc == RST_CYCLES) m_state = 2;
    end else if (m_state == 2 && meas) begin
      acq_hist.push_back(inwin);
      all = (acq_hist.size() >= LOCK_COUNT);
      for (int i = acq_hist.size() - LOCK_COUNT; all && i < acq_hist.size(); i++)
        if (!acq_hist[i]) all = 0;
      if (rail)                                m_state = 4;
      else if (all)                            m_state = 3;
      else if (acq_hist.size() == ACQ_TIMEOUT) m_state = 4;
    end else if (m_state == 3 && meas) begin
      lck_hist.push_back(inwin);
      all = (lck_hist.size() >= UNLOCK_COUNT);
      for (int i = lck_hist.size() - UNLOCK_COUNT; all && i < lck_hist.size(); i++)
        if (lck_hist[i]) all = 0;
      if (rail) begin
        m_state = 4;
      end else if (all) begin
        m_state = 2;
        if (m_relock < 255) m_relock++;
        acq_hist.delete();
        lck_hist.delete();
      end
    end
  endfunction

  function automatic logic [21:0] exp_vec();
    logic rr;
    rr = (m_state == 0) || (m_state == 1) || (m_state == 4);
    return {3'(m_state), 8'(m_sp), m_state == 3, m_state == 4, rr, 8'(m_relock)};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {state, set_period, locked, fault, reg_rst, relock_cnt};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [8:0] dur, input logic [7:0] div);
    duration = dur; adjusted_div = div;
    psi = 1'b1; tick();
    psi = 1'b0; tick();
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (obs_vec() !== RESET_VEC) begin
      miscompares++; $display("FAIL reset_async: dut=%h want=%h", obs_vec(), RESET_VEC);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL reset_release: dut=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_startup();
    int rcycles;
    bit reached;
    rcycles = 0; reached = 0;
    target_period = 8'd100; enable = 1'b1;
    for (int i = 0; i < 20 && !reached; i++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL startup_cycle%0d: dut=%h want=%h", i, obs_vec(), exp_vec());
      end
      if (state == 3'd1 && reg_rst) rcycles++;
      if (state == 3'd2) reached = 1;
    end
    vectors++;
    if (!reached || rcycles != RST_CYCLES || set_period !== 8'd100 || reg_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL startup_seq: reached=%0d rst_cycles=%0d set_period=%0d reg_rst=%b want 1/4/100/0",
               reached, rcycles, set_period, reg_rst);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 7; i++) pulse(9'd101, 8'h80);
    pulse(9'd110, 8'h80);
    for (int i = 0; i < 7; i++) pulse(9'd101, 8'h80);
    vectors++;
    if (locked !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL lock_restart: dut=%h want=%h locked=%b want 0", obs_vec(), exp_vec(), locked);
    end
    pulse(9'd101, 8'h80);
    vectors++;
    if (locked !== 1'b1 || state !== 3'd3 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL lock_8th: dut=%h want=%h locked=%b want 1", obs_vec(), exp_vec(), locked);
    end
  endtask

  task automatic test_unlock();
    pulse(9'd90, 8'h80); pulse(9'd90, 8'h80); pulse(9'd101, 8'h80);
    vectors++;
    if (locked !== 1'b1 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL unlock_2bad1good: dut=%h want=%h locked=%b want 1", obs_vec(), exp_vec(), locked);
    end
    for (int i = 0; i < 3; i++) pulse(9'd90, 8'h80);
    vectors++;
    if (state !== 3'd2 || locked !== 1'b0 || relock_cnt !== 8'd1 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL unlock_3bad: dut=%h want=%h (state 2, relock 1)", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fault_rail();
    pulse(9'd101, 8'hFF);
    vectors++;
    if (state !== 3'd4 || fault !== 1'b1 || reg_rst !== 1'b1 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL rail_acquire: dut=%h want=%h", obs_vec(), exp_vec());
    end
    enable = 1'b0; tick();
    vectors++;
    if (state !== 3'd0 || fault !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL rail_to_idle: dut=%h want=%h", obs_vec(), exp_vec());
    end
    enable = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 8; i++) pulse(9'd100, 8'h40);
    pulse(9'd100, 8'h00);
    vectors++;
    if (state !== 3'd4 || fault !== 1'b1 || locked !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL rail_locked: dut=%h want=%h", obs_vec(), exp_vec());
    end
    enable = 1'b0; tick();
  endtask

  task automatic test_timeout();
    target_period = 8'd100; tick();
    enable = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < ACQ_TIMEOUT - 1; i++) begin
      pulse(9'd150, 8'h80);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL timeout_meas%0d: dut=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (state !== 3'd2) begin
      miscompares++; $display("FAIL timeout_early: state=%0d want 2", state);
    end
    pulse(9'd150, 8'h80);
    vectors++;
    if (state !== 3'd4 || fault !== 1'b1 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL timeout_64th: dut=%h want=%h", obs_vec(), exp_vec());
    end
    enable = 1'b0; tick();
  endtask

  task automatic test_enable_drop();
    target_period = 8'd100; enable = 1'b1;
    repeat (5) tick();
    target_period = 8'd200; tick();
    vectors++;
    if (set_period !== 8'd100 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL frozen_period: set_period=%0d want 100", set_period);
    end
    duration = 9'd150; adjusted_div = 8'hFF;
    psi = 1'b1; tick();
    psi = 1'b0; enable = 1'b0; tick();
    vectors++;
    if (state !== 3'd0 || fault !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL enable_drop_meas: dut=%h want=%h", obs_vec(), exp_vec());
    end
    tick();
    vectors++;
    if (set_period !== 8'd200 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL idle_reload: set_period=%0d want 200", set_period);
    end
  endtask

  task automatic test_no_wrap();
    target_period = 8'd0; tick();
    enable = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 7; i++) pulse(9'd1, 8'h80);
    pulse(9'd511, 8'h80);
    vectors++;
    if (state !== 3'd2 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL err_nowrap: dut=%h want=%h (state 2)", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 8; i++) pulse(9'd2, 8'h80);
    vectors++;
    if (locked !== 1'b1 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL err_edge_tol: dut=%h want=%h (locked)", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs_vec() !== RESET_VEC) begin
      miscompares++; $display("FAIL async_reset: dut=%h want=%h", obs_vec(), RESET_VEC);
    end
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL async_release: dut=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int d;
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      psi = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) d = int'($urandom_range(0, 511));
      else d = m_sp + int'($urandom_range(0, 6)) - 3;
      if (d < 0) d = 0;
      duration = 9'(d);
      adjusted_div = ($urandom_range(0, 399) == 0) ? 8'(($urandom_range(0, 1) == 1) ? 255 : 0)
                                                   : 8'($urandom_range(1, 254));
      enable = ($urandom_range(0, 149) != 0);
      target_period = 8'($urandom_range(0, 255));
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random_cycle%0d: dut=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_startup();
    test_lock();
    test_unlock();
    test_fault_rail();
    test_timeout();
    test_enable_drop();
    test_no_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
